muldiv_sequencer: RTL and testbench

- Iterative multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits beside the ALU in the execute stage; the decoder drives its op strobes.
- It sequences a shared shift/add-subtract datapath over multiple cycles and raises a stall request to the pipeline while a result is pending.

---
 rtl/muldiv_sequencer.sv | 140 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo write HI/LO here only
// CALC  | one shift-add or restoring-subtract step per cycle
// FIXUP | sign correction applied, HI/LO written, done pulsed next cycle
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic             hilo_rd,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP} stateT;

   stateT              state;
   logic [CW-1:0]      counter;
   logic               isDiv;
   logic               negRes;
   logic               negRem;
   logic [WIDTH-1:0]   opB;
   logic [2*WIDTH-1:0] acc;

   logic               isSignedOp;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH:0]     divRem;
   logic [WIDTH:0]     divDiff;
   logic [2*WIDTH-1:0] accNext;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   quotFix;
   logic [WIDTH-1:0]   remFix;
   logic [WIDTH-1:0]   fixHi;
   logic [WIDTH-1:0]   fixLo;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fastProd;
   assign fastProd = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
`endif

   assign stall = busy & (start | hilo_rd | mthi | mtlo);

   // Multiplier and dividend both start in the low half of acc; opB holds multiplicand or divisor.
   always_comb begin
      isSignedOp = ~op[0];
      magA = (isSignedOp && rs_val[WIDTH-1]) ? ({WIDTH{1'b0}} - rs_val) : rs_val;
      magB = (isSignedOp && rt_val[WIDTH-1]) ? ({WIDTH{1'b0}} - rt_val) : rt_val;

      mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
      divRem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      divDiff = divRem - {1'b0, opB};

      // A borrow means the partial remainder was below the divisor, so its top bit is clear.
      if (isDiv) begin
         if (divDiff[WIDTH])
            accNext = {divRem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         accNext = {mulSum, acc[WIDTH-1:1]};
      end

      prodFix = negRes ? ({(2*WIDTH){1'b0}} - acc) : acc;
      quotFix = negRes ? ({WIDTH{1'b0}} - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      remFix  = negRem ? ({WIDTH{1'b0}} - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      fixHi   = isDiv ? remFix  : prodFix[2*WIDTH-1:WIDTH];
      fixLo   = isDiv ? quotFix : prodFix[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         counter <= '0;
         isDiv   <= 1'b0;
         negRes  <= 1'b0;
         negRem  <= 1'b0;
         opB     <= '0;
         acc     <= '0;
         hi      <= '0;
         lo      <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  isDiv   <= op[1];
                  negRes  <= isSignedOp & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  negRem  <= isSignedOp & rs_val[WIDTH-1];
                  opB     <= magB;
                  acc     <= {{WIDTH{1'b0}}, magA};
                  counter <= CW'(WIDTH - 1);
                  state   <= CALC;
                  busy    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                  if (!op[1]) begin
                     acc   <= fastProd;
                     state <= FIXUP;
                  end
`endif
               end else begin
                  if (mthi) hi <= rs_val;
                  if (mtlo) lo <= rs_val;
               end
            end
            CALC: begin
               acc     <= accNext;
               counter <= counter - CW'(1);
               if (counter == '0) state <= FIXUP;
            end
            FIXUP: begin
               hi    <= fixHi;
               lo    <= fixLo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO queued at issue, checked when done pulses.
module tb_muldiv_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mthi;
   logic        mtlo;
   logic        hilo_rd;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;
   logic        done;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .mthi(mthi), .mtlo(mtlo), .hilo_rd(hilo_rd),
      .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passCnt = 0;
   int totalCnt = 0;
   int doneCnt = 0;
   int opCnt = 0;
   logic [63:0] expQ[$];

   task automatic checkWord(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %b, expected %b", name, act, exp);
   endtask

   // Reference model in plain 64-bit arithmetic; result packed as {HI, LO}.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      longint la, lb, q, r;
      logic [63:0] res;
      sa = a; sb = b; la = sa; lb = sb;
      case (o)
         2'd0: res = la * lb;
         2'd1: res = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 32'd0) res = {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
            else begin
               q = la / lb;
               r = la % lb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   function automatic int expBusyCycles(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
      return o[1] ? 33 : 1;
`else
      return (o == 2'd0) ? 33 : 33;
`endif
   endfunction

   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            doneCnt++;
            if (expQ.size() == 0) begin
               totalCnt++;
               $display("FAIL unexpectedDone: done=1 with no operation outstanding, expected done=0");
            end else begin
               e = expQ.pop_front();
               checkWord("result", {hi, lo}, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected bench to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit rd, input bit midAbuse, input bit withMthi);
      int cnt;
      logic [31:0] hiBefore;
      @(negedge clk);
      hiBefore = hi;
      op = o; rs_val = a; rt_val = b; start = 1'b1; hilo_rd = rd; mthi = withMthi;
      expQ.push_back(model(o, a, b));
      opCnt++;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      if (withMthi) checkWord("startOverMthi", {32'd0, hi}, {32'd0, hiBefore});
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         if (rd) checkBit("stallWhileRd", stall, 1'b1);
         if (midAbuse && cnt == 2) begin
            start = 1'b1; mtlo = 1'b1; rs_val = $urandom; op = 2'($urandom_range(0, 3));
            #1 checkBit("stallOnStartBusy", stall, 1'b1);
         end
         if (midAbuse && cnt == 3) begin
            start = 1'b0; mtlo = 1'b0;
         end
         cnt++;
         @(negedge clk);
      end
      start = 1'b0; mtlo = 1'b0;
      checkWord("busyCycles", 64'(cnt), 64'(expBusyCycles(o)));
      checkBit("doneAfterBusy", done, 1'b1);
      if (rd) checkBit("stallAfterDone", stall, 1'b0);
      hilo_rd = 1'b0;
      @(negedge clk);
      checkBit("donePulseOnce", done, 1'b0);
      checkBit("idleAfterDone", busy, 1'b0);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      logic [1:0]  rstOp;
      bit sawDone;
      rst = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
      mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
      repeat (2) @(negedge clk);
      checkWord("rstHiLo", {hi, lo}, 64'd0);
      checkBit("rstBusy", busy, 1'b0);
      checkBit("rstStall", stall, 1'b0);
      checkBit("rstDone", done, 1'b0);
      rst = 1'b0;

      runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      checkWord("multuMax", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      runOp(2'd0, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0, 1'b0);
      checkWord("multNeg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      runOp(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
      checkWord("divNeg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      runOp(2'd3, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
      checkWord("divuByZero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
      runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      checkWord("divOverflow", {hi, lo}, 64'h0000_0000_8000_0000);
      runOp(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 1'b0);
      runOp(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
      checkWord("multuSmall", {hi, lo}, 64'd42);

      runOp(2'd3, $urandom, $urandom_range(1, 1000), 1'b1, 1'b0, 1'b0);
      runOp(2'd3, 32'd12345, 32'd17, 1'b0, 1'b1, 1'b0);
      runOp(2'd0, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hCAFE_BABE;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      checkWord("mthiMtloBoth", {hi, lo}, 64'hCAFE_BABE_CAFE_BABE);

      // Reset during CALC cycle 10 after HI/LO were loaded by mthi/mtlo.
      mthi = 1'b1; rs_val = 32'h1234;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b1; rs_val = 32'h5678;
      @(negedge clk);
      mtlo = 1'b0;
      checkWord("mtValues", {hi, lo}, 64'h0000_1234_0000_5678);
`ifdef MULDIV_FAST_MUL_EN
      rstOp = 2'd3;
`else
      rstOp = 2'd1;
`endif
      op = rstOp; rs_val = $urandom; rt_val = $urandom; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      checkBit("busyBeforeRst", busy, 1'b1);
      rst = 1'b1;
      #1;
      checkWord("rstMidOpHiLo", {hi, lo}, 64'd0);
      checkBit("rstMidOpBusy", busy, 1'b0);
      checkBit("rstMidOpDone", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) sawDone = 1'b1;
      end
      checkBit("noDoneAfterRst", sawDone, 1'b0);
      checkBit("idleAfterRst", busy, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         runOp(ro, ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      @(negedge clk);
      checkWord("queueEmpty", 64'(expQ.size()), 64'd0);
      checkWord("doneCount", 64'(doneCnt), 64'(opCnt));
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
